shift_register_burst: RTL and testbench

Parametrised successor to the team's 4-bit shift register. Holds a WIDTH-bit register and supports parallel load, logical/arithmetic shifts and rotates in both directions, plus an autonomous burst mode. In burst mode the block performs N consecutive shifts under a busy/done handshake. It sits between a controller and serial pins, acting as a serializer, deserializer or barrel-by-steps shifter.

---
 rtl/shift_register_burst_pkg.sv | 22 ++
 rtl/shift_register_burst_shift_step.sv | 49 ++++
 rtl/shift_register_burst.sv | 110 +++++++++++
 tb/tb_shift_register_burst.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/shift_register_burst_pkg.sv
// Shared mode codes and FSM state encoding for the burst shift register.
package shift_register_burst_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_register_burst_shift_step.sv
// Combinational single-step shifter/rotator; LOAD, HOLD and reserved codes pass the register through.
module shift_step
  import shift_register_burst_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]  i_reg,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_seq,
  output logic [WIDTH-1:0]  o_next_c,
  output logic              o_bit_c,
  output logic              o_bit_valid_c
);

  always_comb begin
    o_next_c      = i_reg;
    o_bit_c       = 1'b0;
    o_bit_valid_c = 1'b0;
    case (mode_t'(i_mode))
      MODE_SHL: begin
        o_next_c      = {i_reg[WIDTH-2:0], i_seq};
        o_bit_c       = i_reg[WIDTH-1];
        o_bit_valid_c = 1'b1;
      end
      MODE_SHR: begin
        o_next_c      = {i_seq, i_reg[WIDTH-1:1]};
        o_bit_c       = i_reg[0];
        o_bit_valid_c = 1'b1;
      end
      MODE_ROL: begin
        o_next_c      = {i_reg[WIDTH-2:0], i_reg[WIDTH-1]};
        o_bit_c       = i_reg[WIDTH-1];
        o_bit_valid_c = 1'b1;
      end
      MODE_ROR: begin
        o_next_c      = {i_reg[0], i_reg[WIDTH-1:1]};
        o_bit_c       = i_reg[0];
        o_bit_valid_c = 1'b1;
      end
      MODE_ASR: begin
        o_next_c      = {i_reg[WIDTH-1], i_reg[WIDTH-1:1]};
        o_bit_c       = i_reg[0];
        o_bit_valid_c = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_register_burst.sv
// WIDTH-bit shift register with single-op and N-step burst execution under a busy/done handshake.
module shift_register_burst
  import shift_register_burst_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk_in,
  input  logic              n_rst_in,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              op_valid_in,
  input  logic              burst_start_in,
  input  logic [CNT_W-1:0]  burst_len_in,
  input  logic              seq_in,
  input  logic [WIDTH-1:0]  parallel_in,
  output logic [WIDTH-1:0]  parallel_out,
  output logic              seq_out,
  output logic              busy_out,
  output logic              done_out
);

  state_t             r_state;
  mode_t              r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_data;
  logic               r_seq;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  mode_t              w_mode_nxt;
  mode_t              w_step_mode;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               w_seq_nxt;
  logic               w_done_nxt;
  logic [WIDTH-1:0]   w_step_data;
  logic               w_step_bit;
  logic               w_step_bit_vld;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_reg         (r_data),
    .i_mode        (w_step_mode),
    .i_seq         (seq_in),
    .o_next_c      (w_step_data),
    .o_bit_c       (w_step_bit),
    .o_bit_valid_c (w_step_bit_vld)
  );

  // Next-state, step selection and register updates
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_step_mode = MODE_HOLD;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (burst_start_in) begin
          w_mode_nxt = mode_t'(mode_in);
          w_cnt_nxt  = burst_len_in;
          if (burst_len_in != '0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (op_valid_in) begin
          w_step_mode = mode_t'(mode_in);
        end
      end
      ST_RUN: begin
        w_step_mode = r_mode;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_data_nxt = (w_step_mode == MODE_LOAD) ? parallel_in : w_step_data;
    w_seq_nxt  = w_step_bit_vld ? w_step_bit : r_seq;
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_data  <= '0;
      r_seq   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_seq   <= w_seq_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= w_done_nxt;
    end
  end

  assign parallel_out = r_data;
  assign seq_out      = r_seq;
  assign busy_out     = r_busy;
  assign done_out     = r_done;

endmodule

// File: tb/tb_shift_register_burst.sv
// Scoreboard bench for shift_register_burst: per-cycle expectations queued at drive time, popped after the edge.
module tb_shift_register_burst;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk_in = 1'b0;
  logic          n_rst_in;
  logic [2:0]    mode_in;
  logic          op_valid_in;
  logic          burst_start_in;
  logic [CW-1:0] burst_len_in;
  logic          seq_in;
  logic [W-1:0]  parallel_in;
  logic [W-1:0]  parallel_out;
  logic          seq_out;
  logic          busy_out;
  logic          done_out;

  shift_register_burst #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_in         (clk_in),
    .n_rst_in       (n_rst_in),
    .mode_in        (mode_in),
    .op_valid_in    (op_valid_in),
    .burst_start_in (burst_start_in),
    .burst_len_in   (burst_len_in),
    .seq_in         (seq_in),
    .parallel_in    (parallel_in),
    .parallel_out   (parallel_out),
    .seq_out        (seq_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [W-1:0] data;
    logic         seq;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0]  m_data = '0;
  logic          m_seq  = 1'b0;
  logic [2:0]    m_mode = 3'd0;
  int            m_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference of one operation on the model register
  task automatic model_op(input logic [2:0] mode, input logic s, input logic [W-1:0] pin);
    case (mode)
      3'd1: m_data = pin;
      3'd2: begin m_seq = m_data[W-1]; m_data = (m_data << 1) | W'(s); end
      3'd3: begin m_seq = m_data[0];   m_data = (m_data >> 1) | (W'(s) << (W-1)); end
      3'd4: begin m_seq = m_data[W-1]; m_data = (m_data << 1) | (m_data >> (W-1)); end
      3'd5: begin m_seq = m_data[0];   m_data = (m_data >> 1) | (m_data << (W-1)); end
      3'd6: begin m_seq = m_data[0];   m_data = W'($signed(m_data) >>> 1); end
      default: ;
    endcase
  endtask

  task automatic drive(input string tag, input logic [2:0] mode, input logic valid,
                       input logic start, input logic [CW-1:0] len, input logic s,
                       input logic [W-1:0] pin);
    exp_t e;
    exp_t got;
    logic eb;
    logic ed;
    mode_in = mode; op_valid_in = valid; burst_start_in = start;
    burst_len_in = len; seq_in = s; parallel_in = pin;
    eb = 1'b0; ed = 1'b0;
    if (m_left == 0) begin
      if (start) begin
        m_mode = mode;
        m_left = int'(len);
        eb = (len != '0);
        ed = (len == '0);
      end else if (valid) begin
        model_op(mode, s, pin);
      end
    end else begin
      model_op(m_mode, s, pin);
      m_left--;
      eb = (m_left != 0);
      ed = (m_left == 0);
    end
    e = '{data: m_data, seq: m_seq, busy: eb, done: ed};
    sb_q.push_back(e);
    @(posedge clk_in);
    #1;
    got = '{data: parallel_out, seq: seq_out, busy: busy_out, done: done_out};
    e = sb_q.pop_front();
    check({tag, ".data"}, 32'(got.data), 32'(e.data));
    check({tag, ".seq"},  32'(got.seq),  32'(e.seq));
    check({tag, ".busy"}, 32'(got.busy), 32'(e.busy));
    check({tag, ".done"}, 32'(got.done), 32'(e.done));
  endtask

  logic [7:0] deser_bits;

  initial begin
    n_rst_in = 1'b0; mode_in = '0; op_valid_in = 1'b0; burst_start_in = 1'b0;
    burst_len_in = '0; seq_in = 1'b0; parallel_in = '0;
    #12;
    check("rst.data", 32'(parallel_out), 32'h0);
    check("rst.seq",  32'(seq_out), 32'h0);
    check("rst.busy", 32'(busy_out), 32'h0);
    check("rst.done", 32'(done_out), 32'h0);
    @(negedge clk_in);
    n_rst_in = 1'b1;

    // Single ops
    drive("load_a5", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'hA5);
    drive("shr1",    3'd3, 1'b1, 1'b0, 4'd0, 1'b1, 8'h00);
    check("shr1.lit", 32'(parallel_out), 32'hD2);
    check("shr1.bit", 32'(seq_out), 32'h1);
    drive("shl0",    3'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    check("shl0.lit", 32'(parallel_out), 32'hA4);
    check("shl0.bit", 32'(seq_out), 32'h1);
    drive("hold",    3'd0, 1'b1, 1'b0, 4'd0, 1'b1, 8'hFF);
    drive("rsvd",    3'd7, 1'b1, 1'b0, 4'd0, 1'b1, 8'hFF);
    drive("idle",    3'd1, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);

    // ASR burst N=3 from 0x80
    drive("load_80", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h80);
    drive("asr_st",  3'd6, 1'b0, 1'b1, 4'd3, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) drive("asr", 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    check("asr.lit", 32'(parallel_out), 32'hF0);
    drive("asr_post", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);

    // ROL burst N=8 with ignored LOAD mid-burst, then back-to-back start in the done cycle
    drive("load_3c", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h3C);
    drive("rol_st",  3'd4, 1'b0, 1'b1, 4'd8, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++)
      drive("rol", (i == 3) ? 3'd1 : 3'd2, (i == 3), (i == 5), 4'd2, 1'b1, 8'hFF);
    check("rol.lit", 32'(parallel_out), 32'h3C);

    // Deserialize: SHR burst N=8 started while done is high
    deser_bits = 8'b0100_1101;
    drive("des_st",  3'd3, 1'b0, 1'b1, 4'd8, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) drive("des", 3'd0, 1'b0, 1'b0, 4'd0, deser_bits[i], 8'h00);
    check("des.lit", 32'(parallel_out), 32'h4D);

    // Zero-length burst, then simultaneous op_valid + burst_start
    drive("load_5a", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h5A);
    drive("n0",      3'd2, 1'b1, 1'b1, 4'd0, 1'b1, 8'h00);
    drive("n0_post", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    check("n0.lit",  32'(parallel_out), 32'h5A);
    drive("both_st", 3'd5, 1'b1, 1'b1, 4'd1, 1'b0, 8'h00);
    drive("both",    3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    check("both.lit", 32'(parallel_out), 32'h2D);

    // Max-length LOAD burst
    drive("ld_st",  3'd1, 1'b0, 1'b1, 4'd15, 1'b0, 8'h00);
    for (int i = 0; i < 15; i++) drive("ldb", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'(i + 1));

    // Asynchronous reset two steps into an N=5 burst
    drive("rs_st",  3'd2, 1'b0, 1'b1, 4'd5, 1'b1, 8'h00);
    drive("rs1",    3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    drive("rs2",    3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    n_rst_in = 1'b0;
    #1;
    check("arst.data", 32'(parallel_out), 32'h0);
    check("arst.seq",  32'(seq_out), 32'h0);
    check("arst.busy", 32'(busy_out), 32'h0);
    check("arst.done", 32'(done_out), 32'h0);
    m_data = '0; m_seq = 1'b0; m_mode = 3'd0; m_left = 0;
    #2;
    n_rst_in = 1'b1;
    for (int i = 0; i < 4; i++) drive("post_rst", 3'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    drive("post_ld", 3'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'h11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
